// File: rtl/mont_pkg.sv
// Shared Montgomery constants and FSM encoding, also used by the inversion stage.
// MONT_MUL_RADIX4_EN selects two multiplier bits per iteration instead of one.
package mont_pkg;

  localparam int MONT_WIDTH = 192;

`ifdef MONT_MUL_RADIX4_EN
  localparam int MONT_RADIX_BITS = 2;
`else
  localparam int MONT_RADIX_BITS = 1;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Accumulator keeps S < 2n: one guard bit for 2n plus one per radix bit of headroom.
  function automatic int montSumWidth(input int width);
    return width + 1 + MONT_RADIX_BITS;
  endfunction

  function automatic int montIterations(input int width);
    return width / MONT_RADIX_BITS;
  endfunction

endpackage

// File: rtl/mont_mul_step.sv
// One combinational Montgomery iteration: S = (S + d*b + q*n) / 2^k.
// Radix 2 by default, radix 4 when MONT_MUL_RADIX4_EN is defined.
module mont_mul_step
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic [montSumWidth(WIDTH)-1:0] i_s,
  input  logic [MONT_RADIX_BITS-1:0]     i_digit,
  input  logic [WIDTH-1:0]               i_b,
  input  logic [WIDTH-1:0]               i_n,
  output logic [montSumWidth(WIDTH)-1:0] o_s
);

  localparam int SW = montSumWidth(WIDTH);
  localparam int XW = SW + 1;

  logic [XW-1:0] w_s;
  logic [XW-1:0] w_b;
  logic [XW-1:0] w_n;
  logic [XW-1:0] w_sum;
  logic [XW-1:0] w_total;

  assign w_s = XW'(i_s);
  assign w_b = XW'(i_b);
  assign w_n = XW'(i_n);

`ifdef MONT_MUL_RADIX4_EN
  logic [1:0] w_q;

  // q = S' * (-n^-1 mod 4) makes S' + q*n divisible by 4.
  always_comb begin
    w_sum   = w_s + (i_digit[0] ? w_b : '0) + (i_digit[1] ? (w_b << 1) : '0);
    w_q     = w_sum[1:0] * (i_n[1] ? 2'd1 : 2'd3);
    w_total = w_sum + (w_q[0] ? w_n : '0) + (w_q[1] ? (w_n << 1) : '0);
  end

  assign o_s = SW'(w_total >> 2);
`else
  always_comb begin
    w_sum   = w_s + (i_digit[0] ? w_b : '0);
    w_total = w_sum + (w_sum[0] ? w_n : '0);
  end

  assign o_s = SW'(w_total >> 1);
`endif

endmodule

// File: rtl/mont_mul.sv
// Bit-serial Montgomery multiplier: o_result = a*b*2^-WIDTH mod n.
// MONT_MUL_RADIX4_EN halves the iteration count; results are identical either way.
module mont_mul
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy
);

  localparam int SW   = montSumWidth(WIDTH);
  localparam int DW   = MONT_RADIX_BITS;
  localparam int ITER = montIterations(WIDTH);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SW-1:0]    r_s;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_finished;
  logic             r_busy;

  logic [SW-1:0]    w_sNext;
  logic [SW-1:0]    w_nExt;
  logic [SW-1:0]    w_final;

  mont_mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_s    (r_s),
    .i_digit(r_a[DW-1:0]),
    .i_b    (r_b),
    .i_n    (r_n),
    .o_s    (w_sNext)
  );

  assign w_nExt  = SW'(r_n);
  assign w_final = (r_s >= w_nExt) ? (r_s - w_nExt) : r_s;

  // The multiplicand is shifted down so the current digit always sits in the low bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_finished <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_n     <= i_n;
            r_a     <= i_a;
            r_b     <= i_b;
            r_s     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s   <= w_sNext;
          r_a   <= r_a >> DW;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_result <= WIDTH'(w_final);
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_finished <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_result   = r_result;
  assign o_finished = r_finished;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul: directed 8-bit vectors against a modular-arithmetic model,
// plus random 192-bit vectors. Honours MONT_MUL_RADIX4_EN for the expected latency.
module tb_mont_mul;

`ifdef MONT_MUL_RADIX4_EN
  localparam int LAT8   = 6;
  localparam int LAT192 = 98;
`else
  localparam int LAT8   = 10;
  localparam int LAT192 = 194;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic         s8Start = 1'b0;
  logic [7:0]   s8N = 8'd0;
  logic [7:0]   s8A = 8'd0;
  logic [7:0]   s8B = 8'd0;
  logic [7:0]   o8Result;
  logic         o8Finished;
  logic         o8Busy;

  logic         s192Start = 1'b0;
  logic [191:0] s192N = '0;
  logic [191:0] s192A = '0;
  logic [191:0] s192B = '0;
  logic [191:0] o192Result;
  logic         o192Finished;
  logic         o192Busy;

  int checks = 0;
  int errors = 0;
  bit cmpEnable = 1'b0;

  int         mRem = 0;
  bit         mFin = 1'b0;
  bit         mDef = 1'b1;
  bit         mPendDef = 1'b1;
  logic [7:0] mResult = 8'd0;
  logic [7:0] mPending = 8'd0;

  always #5 clock = ~clock;

  mont_mul #(.WIDTH(8)) dut8 (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_start   (s8Start),
    .i_n       (s8N),
    .i_a       (s8A),
    .i_b       (s8B),
    .o_result  (o8Result),
    .o_finished(o8Finished),
    .o_busy    (o8Busy)
  );

  mont_mul #(.WIDTH(192)) dut192 (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_start   (s192Start),
    .i_n       (s192N),
    .i_a       (s192A),
    .i_b       (s192B),
    .o_result  (o192Result),
    .o_finished(o192Finished),
    .o_busy    (o192Busy)
  );

  task automatic checkOutput(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // The unique r < n with r * 2^8 == a*b (mod n).
  function automatic logic [7:0] modelMont8(input int n, input int a, input int b);
    int target;
    target = (a * b) % n;
    for (int r = 0; r < n; r++) begin
      if (((r * 256) % n) == target) return 8'(r);
    end
    return 8'd0;
  endfunction

  // Transaction-level model of the 8-bit instance: accept, wait the latency, publish.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mRem    = 0;
      mFin    = 1'b0;
      mResult = 8'd0;
      mDef    = 1'b1;
    end else begin
      mFin = 1'b0;
      if (mRem > 0) begin
        mRem--;
        if (mRem == 0) begin
          mFin    = 1'b1;
          mResult = mPending;
          mDef    = mPendDef;
        end
      end else if (s8Start) begin
        mRem     = LAT8;
        mPendDef = s8N[0] && (s8A < s8N) && (s8B < s8N);
        mPending = mPendDef ? modelMont8(int'(s8N), int'(s8A), int'(s8B)) : 8'd0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmpEnable) begin
      checkOutput("cmpBusy", 192'(o8Busy), 192'(mRem > 0));
      checkOutput("cmpFinished", 192'(o8Finished), 192'(mFin));
      if ((mFin || mRem == 0) && mDef) begin
        checkOutput("cmpResult", 192'(o8Result), 192'(mResult));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] n, input logic [7:0] a, input logic [7:0] b,
                               output int lat);
    @(negedge clock);
    s8N = n;
    s8A = a;
    s8B = b;
    s8Start = 1'b1;
    @(posedge clock);
    #1;
    s8Start = 1'b0;
    s8N = 8'($urandom);
    s8A = 8'($urandom);
    s8B = 8'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(posedge clock);
      lat++;
      #1;
      if (o8Finished) break;
    end
  endtask

  task automatic run192(input logic [191:0] n, input logic [191:0] a, input logic [191:0] b);
    int lat;
    logic [399:0] lhs;
    logic [399:0] rhs;
    logic [399:0] nWide;
    @(negedge clock);
    s192N = n;
    s192A = a;
    s192B = b;
    s192Start = 1'b1;
    @(posedge clock);
    #1;
    s192Start = 1'b0;
    s192A = '0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clock);
      lat++;
      #1;
      if (o192Finished) break;
    end
    nWide = 400'(n);
    lhs = (400'(o192Result) << 192) % nWide;
    rhs = (400'(a) * 400'(b)) % nWide;
    checkOutput("w192Latency", 192'(lat), 192'(LAT192));
    checkOutput("w192Congruent", lhs[191:0], rhs[191:0]);
    checkOutput("w192Reduced", 192'(o192Result < n), 192'd1);
  endtask

  initial begin
    int lat;
    logic [191:0] rn;
    logic [191:0] ra;
    logic [191:0] rb;

    #2;
    checkOutput("rstResult", 192'(o8Result), 192'd0);
    checkOutput("rstFinished", 192'(o8Finished), 192'd0);
    checkOutput("rstBusy", 192'(o8Busy), 192'd0);
    checkOutput("rstBusy192", 192'(o192Busy), 192'd0);
    @(negedge clock);
    reset = 1'b0;
    cmpEnable = 1'b1;

    applyStimulus(8'd13, 8'd5, 8'd7, lat);
    checkOutput("t1Latency", 192'(lat), 192'(LAT8));
    checkOutput("t1Result", 192'(o8Result), 192'd1);

    applyStimulus(8'd13, 8'd12, 8'd12, lat);
    checkOutput("t2aResult", 192'(o8Result), 192'd3);
    applyStimulus(8'd13, 8'd1, 8'd1, lat);
    checkOutput("t2bResult", 192'(o8Result), 192'd3);
    applyStimulus(8'd13, 8'd0, 8'd9, lat);
    checkOutput("t2cLatency", 192'(lat), 192'(LAT8));
    checkOutput("t2cResult", 192'(o8Result), 192'd0);

    applyStimulus(8'd255, 8'd254, 8'd254, lat);
    checkOutput("t3Result", 192'(o8Result), 192'd1);

    // A second start while running must be dropped.
    fork
      applyStimulus(8'd13, 8'd5, 8'd7, lat);
      begin
        repeat (3) @(posedge clock);
        #2;
        s8N = 8'd255;
        s8A = 8'd3;
        s8B = 8'd200;
        s8Start = 1'b1;
        @(posedge clock);
        #2;
        s8Start = 1'b0;
      end
    join
    checkOutput("t4Latency", 192'(lat), 192'(LAT8));
    checkOutput("t4Result", 192'(o8Result), 192'd1);
    repeat (2) @(posedge clock);
    checkOutput("t4Held", 192'(o8Result), 192'd1);

    // Reset in the middle of a run.
    @(negedge clock);
    s8N = 8'd13;
    s8A = 8'd12;
    s8B = 8'd12;
    s8Start = 1'b1;
    @(posedge clock);
    #1;
    s8Start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5Busy", 192'(o8Busy), 192'd0);
    checkOutput("t5Finished", 192'(o8Finished), 192'd0);
    checkOutput("t5Result", 192'(o8Result), 192'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'd13, 8'd12, 8'd12, lat);
    checkOutput("t5AfterLatency", 192'(lat), 192'(LAT8));
    checkOutput("t5AfterResult", 192'(o8Result), 192'd3);

    for (int v = 0; v < 20; v++) begin
      applyStimulus(8'd251, 8'($urandom_range(250, 0)), 8'($urandom_range(250, 0)), lat);
    end

    for (int v = 0; v < 100; v++) begin
      rn = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rn[0] = 1'b1;
      rn[191] = 1'b1;
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ra = ra % rn;
      rb = rb % rn;
      run192(rn, ra, rb);
    end

    cmpEnable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
